// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with whole-line refill.
// Hits return in the same cycle. A miss stalls fetch until the line is installed and the lookup is replayed.
module icache_dm #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_en,
    input  logic [31:0]  cpu_addr,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_stall,
    input  logic         flush,
    output logic         miss,
    output logic [31:0]  miss_addr,
    input  logic         accept,
    input  logic         wen_fill,
    input  logic [255:0] wfill,
    output logic         wen_back,
    output logic [31:0]  waddr,
    output logic [255:0] wback,
    input  logic         fin,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int TAG_W = 27 - INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, MISS, DONE} state_t;

    state_t                 state;
    logic [SETS-1:0]        valid;
    logic [TAG_W-1:0]       tag_arr [SETS];
    logic [255:0]           data [SETS];
    logic                   pend;
    logic [INDEX_WIDTH-1:0] idx;
    logic [INDEX_WIDTH-1:0] fidx;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   unused;

    assign idx = cpu_addr[4+INDEX_WIDTH:5];
    assign tag = cpu_addr[31:5+INDEX_WIDTH];
    assign fidx = miss_addr[4+INDEX_WIDTH:5];
    assign hit = valid[idx] && tag_arr[idx] == tag;
    assign cpu_rdata = data[idx][{cpu_addr[4:2], 5'b0} +: 32];
    // A flush in IDLE stalls the lookup so nothing is returned from a line being invalidated.
    assign cpu_stall = state != IDLE || (cpu_en && (!hit || flush));
    assign wen_back = 1'b0;
    assign waddr = '0;
    assign wback = '0;
    assign unused = ^{accept, fin, cpu_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= '0;
            pend <= 1'b0;
            miss <= 1'b0;
            miss_addr <= '0;
            hit_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            if (cpu_en && !cpu_stall) hit_cnt <= hit_cnt + 32'd1;
            case (state)
                IDLE: begin
                    if (flush) valid <= '0;
                    else if (cpu_en && !hit) begin
                        miss <= 1'b1;
                        miss_addr <= {cpu_addr[31:5], 5'b0};
                        miss_cnt <= miss_cnt + 32'd1;
                        state <= MISS;
                    end
                end
                MISS: begin
                    if (flush) pend <= 1'b1;
                    // miss drops at the fill edge so the refill side never re-samples it
                    if (wen_fill) begin
                        valid[fidx] <= !(pend || flush);
                        miss <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (pend || flush) begin
                        valid <= '0;
                        pend <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == MISS && wen_fill) begin
            data[fidx] <= wfill;
            tag_arr[fidx] <= miss_addr[31:5+INDEX_WIDTH];
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: randomized bench for icache_dm with a set-level reference model and a refill-interface model.
module tb_icache_dm;
    logic         clk = 1'b0;
    logic         rst, cpu_en, flush, accept, wen_fill, fin;
    logic [31:0]  cpu_addr, cpu_rdata, miss_addr, waddr, hit_cnt, miss_cnt;
    logic         cpu_stall, miss, wen_back;
    logic [255:0] wfill, wback;

    always #5 clk = ~clk;

    icache_dm #(.INDEX_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .flush(flush), .miss(miss), .miss_addr(miss_addr), .accept(accept),
        .wen_fill(wen_fill), .wfill(wfill), .wen_back(wen_back), .waddr(waddr), .wback(wback),
        .fin(fin), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int          n_cmp = 0, n_err = 0;
    bit          mvalid [64];
    logic [31:0] mline [64];
    int          phase, cnt;
    bit          pend, busy, inject, armed, rst_was, obs_stall, rnd_flush;
    logic [31:0] exp_maddr, mhits, mmisses, rf_addr, last_req, obs_rdata, n_starts, n_fills;
    logic [31:0] h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Backing memory: word = line address rotated by 16, plus word number.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] la;
        la = {a[31:5], 5'b0};
        return {la[15:0], la[31:16]} + {29'd0, a[4:2]};
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(la + 32'(4 * k));
        return l;
    endfunction

    task automatic clear_model();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
    endtask

    task automatic tick();
        int s;
        bit mh, es;
        logic [31:0] la;
        #1;
        s = int'(cpu_addr[10:5]);
        la = {cpu_addr[31:5], 5'b0};
        mh = mvalid[s] && mline[s] == la;
        es = phase != 0 || (cpu_en && (!mh || flush));
        obs_stall = cpu_stall;
        obs_rdata = cpu_rdata;
        if (armed) begin
            check("stall", 32'(cpu_stall), 32'(es));
            if (cpu_en && !es) check("rdata", cpu_rdata, mem_word(cpu_addr));
            check("miss", 32'(miss), 32'(phase == 1));
            if (phase == 1) check("miss_addr", miss_addr, exp_maddr);
            check("hit_cnt", hit_cnt, mhits);
            check("miss_cnt", miss_cnt, mmisses);
        end
        if (rst) begin
            armed = 1'b1;
            phase = 0;
            pend = 1'b0;
            mhits = 0;
            mmisses = 0;
            clear_model();
        end else if (armed) begin
            if (cpu_en && !es) mhits++;
            if (phase == 0) begin
                if (flush) clear_model();
                else if (cpu_en && !mh) begin
                    phase = 1;
                    exp_maddr = la;
                    mmisses++;
                end
            end else if (phase == 1) begin
                if (flush) pend = 1'b1;
                if (wen_fill) begin
                    mline[int'(exp_maddr[10:5])] = exp_maddr;
                    mvalid[int'(exp_maddr[10:5])] = !pend;
                    phase = 2;
                end
            end else begin
                phase = 0;
                if (pend || flush) begin
                    clear_model();
                    pend = 1'b0;
                end
            end
        end
        rst_was = rst;
        @(negedge clk);
        // Refill interface: samples miss once per request, returns the line after a random delay.
        wen_fill = 1'b0;
        if (rst_was) begin
            busy = 1'b0;
            n_starts = 0;
            n_fills = 0;
        end else if (busy) begin
            if (cnt == 0) begin
                wen_fill = 1'b1;
                wfill = line_of(rf_addr);
                busy = 1'b0;
                n_fills++;
            end else cnt--;
        end else if (miss) begin
            busy = 1'b1;
            rf_addr = miss_addr;
            last_req = miss_addr;
            cnt = int'($urandom_range(0, 9));
            n_starts++;
            check("one_req", n_starts, mmisses);
        end else if (inject && phase != 1 && $urandom_range(0, 15) == 0) begin
            wen_fill = 1'b1;
            wfill = {8{$urandom}};
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        int n;
        cpu_en = 1'b1;
        cpu_addr = a;
        n = 0;
        do begin
            flush = rnd_flush && $urandom_range(0, 40) == 0;
            tick();
            n++;
        end while (obs_stall && n < 100);
        flush = 1'b0;
        check("fetch_done", 32'(obs_stall), 32'd0);
    endtask

    initial begin
        rst = 1'b1; cpu_en = 1'b0; flush = 1'b0; accept = 1'b1; wen_fill = 1'b0; fin = 1'b0;
        wfill = '0; cpu_addr = '0; inject = 1'b0; rnd_flush = 1'b0; busy = 1'b0; armed = 1'b0;
        rst_was = 1'b0; n_starts = 0; n_fills = 0; phase = 0; pend = 1'b0; mhits = 0; mmisses = 0;
        clear_model();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check("wb_const", 32'({wen_back, waddr != 0, wback != 0}), 32'd0);

        fetch(32'h0000_1004);
        check("cold_rdata", obs_rdata, 32'h1000_0001);
        check("cold_mcnt", miss_cnt, 32'd1);
        check("cold_req", last_req, 32'h0000_1000);

        h0 = hit_cnt;
        fetch(32'h0000_1000);
        check("hit0_rdata", obs_rdata, 32'h1000_0000);
        fetch(32'h0000_101C);
        check("hit7_rdata", obs_rdata, 32'h1000_0007);
        check("hits_cnt", hit_cnt, h0 + 32'd2);
        check("hits_mcnt", miss_cnt, 32'd1);

        fetch(32'h0000_1000);
        fetch(32'h0000_1800);
        check("conf_rdata", obs_rdata, 32'h1800_0000);
        fetch(32'h0000_1000);
        check("conf_mcnt", miss_cnt, 32'd3);

        cpu_en = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fetch(32'h0000_1000);
        check("flush_req", last_req, 32'h0000_1000);
        check("flush_mcnt", miss_cnt, 32'd4);

        cpu_en = 1'b1;
        cpu_addr = 32'h0000_1800;
        tick();
        tick();
        check("fm_in_miss", 32'(miss), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fetch(32'h0000_1800);
        check("fm_mcnt", miss_cnt, 32'd6);
        check("fm_rdata", obs_rdata, 32'h1800_0000);

        cpu_addr = 32'h0000_2000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_en = 1'b0;
        tick();
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_hcnt", hit_cnt, 32'd0);
        check("rst_mcnt", miss_cnt, 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        fetch(32'h0000_1000);
        check("rst_cold", miss_cnt, 32'd1);

        inject = 1'b1;
        rnd_flush = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cpu_en = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                cpu_addr = $urandom;
                flush = $urandom_range(0, 15) == 0;
                tick();
            end
            flush = 1'b0;
            fetch($urandom_range(0, 1) == 0 ? $urandom_range(0, 32'h7FF) : $urandom_range(0, 32'hFFFFF));
        end
        inject = 1'b0;
        rnd_flush = 1'b0;
        cpu_en = 1'b0;
        repeat (3) tick();
        check("fills_match", n_fills, mmisses);
        check("many_misses", 32'(mmisses >= 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the fetch stage and the line-refill interface. Fetch lookups that hit return the word in the same cycle. On a miss, the cache stalls fetch and issues a line-aligned 256-bit refill request. It then installs the returned line and replays the lookup. It never issues write-backs; the write-back port toward the refill interface is driven inactive.

## Interface
- INDEX_WIDTH, default 6: number of sets is 2^INDEX_WIDTH; line is 32 bytes (8 words); offset is addr[4:0], index is addr[4+INDEX_WIDTH:5], tag is addr[31:5+INDEX_WIDTH].
- clk  input  1  clock; reset rst, synchronous, active-high.
- rst  input  1  synchronous active-high reset.
- cpu_en  input  1  fetch lookup request, level, evaluated every cycle.
- cpu_addr  input  32  fetch byte address; addr[1:0] ignored; must be held stable while cpu_stall=1.
- cpu_rdata  output  32  fetched word, combinational, valid when cpu_en=1 and cpu_stall=0.
- cpu_stall  output  1  combinational: cpu_en & ~hit, or state≠IDLE.
- flush  input  1  invalidate all lines (fence.i).
- miss  output  1  refill request level, registered.
- miss_addr  output  32  line-aligned refill address {tag,index,5'b0}, registered.
- accept  input  1  refill accept; not used for control, because it may stay high after the first accept.
- wen_fill  input  1  one-cycle strobe: wfill holds the complete line.
- wfill  input  256  refill line; word k is at wfill[32k+:32].
- wen_back  output  1  constant 0.
- waddr  output  32  constant 0.
- wback  output  256  constant 0.
- fin  input  1  ignored.
- hit_cnt  output  32  count of cycles with cpu_en=1 and cpu_stall=0; wraps at 2^32.
- miss_cnt  output  32  count of refill requests issued; wraps at 2^32.

## Operation
- Storage is per set: a valid bit, a tag, and a 256-bit data register.
- Lookup (comb): hit = valid[idx] & (tag_arr[idx]==cpu_addr tag); cpu_rdata = data[idx][32*cpu_addr[4:2]+:32].
- FSM states: IDLE, MISS, DONE.
- IDLE: if cpu_en & ~hit & ~flush, latch miss_addr = {cpu_addr[31:5],5'b0}, set miss=1, increment miss_cnt, and go to MISS.
- MISS: hold miss=1 and hold miss_addr. On wen_fill=1, write wfill into data, write the tag, set valid, clear miss, and go to DONE.
- DONE: stall for one cycle (the refill interface returns to idle), then go to IDLE. The replayed lookup hits.
- Flush in IDLE: all valid bits clear at the clock edge. In that cycle, lookups are treated as stalled, and no miss is issued.
- Flush in MISS or DONE: a pending-flush flag is set. The returning line is written but its valid bit is not set. All valid bits clear on entry to IDLE.
- wen_fill arriving in IDLE or DONE is ignored, with no array write.
- Reset: all valid bits clear; state=IDLE; miss=0; miss_addr=0; hit_cnt=0; miss_cnt=0; pending flush cleared. The refill interface shares rst, so no refill survives reset.

## Timing
- Hit: 0-cycle latency; cpu_rdata is valid in the cycle of the request.
- Miss detected in cycle N (cpu_stall=1 comb): miss=1 from cycle N+1.
- Refill interface: samples miss at edge N+1, then does 8 SRAM reads. wen_fill is high in cycle F.
- The cache samples wen_fill at end of F: the array is written and miss drops to 0 at that same edge.
  - This guarantees the refill interface sees miss=0 when it re-enters its idle stage, so no duplicate refill is issued.
- Cycle F+1 is DONE (stalled). Cycle F+2 is IDLE, where the lookup hits and cpu_stall=0.
- Miss penalty is F+2−N cycles.
- miss_addr is constant while miss=1.

## Test plan
- Cold miss:
  - Stimulus: reset, then cpu_en=1, addr 0x0000_1004. Refill model returns words 0x1000_0000+k.
  - Required: miss=1 one cycle later with miss_addr=0x0000_1000; stall through DONE; then rdata=0x1000_0001, stall=0. miss_cnt=1.
- Same-line hits:
  - Stimulus: after the cold miss, fetch addrs 0x1000, 0x101C.
  - Required: rdata 0x1000_0000 and 0x1000_0007 with zero stall; hit_cnt +2; miss never rises.
- Conflict eviction (INDEX_WIDTH=6):
  - Stimulus: fetch 0x1000, then 0x1800 (same index 0, different tag), then 0x1000 again.
  - Required: three refills issued; miss_cnt=3.
- Flush:
  - Stimulus: after a fill of 0x1000, pulse flush in IDLE, then fetch 0x1000.
  - Required: a new miss with miss_addr=0x1000.
  - Stimulus: flush during MISS.
  - Required: after the fill, the line stays invalid and the next fetch of that line misses again.
- Reset mid-refill:
  - Stimulus: assert rst while in MISS.
  - Required: next cycle miss=0, counters=0, stall only on fresh misses; the line is not valid.
- No duplicate refill:
  - Stimulus: cpu_en held high across the entire miss, with accept left high permanently.
  - Required: exactly one wen_fill per miss_addr, checked over 100 random cold misses.
